// File: rtl/booth_mult_arb.sv
// Round-robin front end that shares one booth multiplier between two
// requesters and returns a tagged signed product on a valid/ready channel.
//
// state | meaning
// IDLE  | waiting for a request; ready given to the granted requester
// START | one-cycle start pulse to the multiplier, operands held
// WAIT  | waiting for mul_done (first cycle ignored) or timeout
// RESP  | response presented until the consumer takes it
module booth_mult_arb #(
  parameter int N   = 4,
  parameter int TMO = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req0_valid_i,
  input  logic [N-1:0]   req0_m_i,
  input  logic [N-1:0]   req0_q_i,
  output logic           req0_ready_o,
  input  logic           req1_valid_i,
  input  logic [N-1:0]   req1_m_i,
  input  logic [N-1:0]   req1_q_i,
  output logic           req1_ready_o,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic           rsp_id_o,
  output logic [2*N-1:0] rsp_prod_o,
  output logic           rsp_err_o,
  output logic [N-1:0]   mul_m_o,
  output logic [N-1:0]   mul_q_o,
  output logic           mul_start_o,
  input  logic           mul_done_i,
  input  logic [2*N-1:0] mul_prod_i
);

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t         state_q, state_d;
  logic           last_id_q;
  logic           id_q;
  logic [N-1:0]   opm_q;
  logic [N-1:0]   opq_q;
  logic [2*N-1:0] prod_q;
  logic           err_q;
  logic [TW-1:0]  timer_q;

  logic grant_id;
  logic take;
  logic done_ok;
  logic tmo_hit;

  // Round-robin pick: a lone request wins outright, a tie goes away from last_id.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant_id = ~last_id_q;
    end else if (req1_valid_i) begin
      grant_id = 1'b1;
    end
  end

  // Ready is gated by reset so nothing is accepted while rst_i is high.
  assign take    = (state_q == S_IDLE) && !rst_i && (req0_valid_i || req1_valid_i);
  // Done in the first WAIT cycle may be left over from the previous operation.
  assign done_ok = (state_q == S_WAIT) && (timer_q != '0) && mul_done_i;
  assign tmo_hit = (state_q == S_WAIT) && (timer_q == TW'(TMO - 1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (done_ok || tmo_hit) state_d = S_RESP;
      S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: handshakes decoded from state, payload straight from registers.
  always_comb begin
    req0_ready_o = take && !grant_id;
    req1_ready_o = take && grant_id;
    mul_start_o  = (state_q == S_START);
    rsp_valid_o  = (state_q == S_RESP);
    mul_m_o      = opm_q;
    mul_q_o      = opq_q;
    rsp_id_o     = id_q;
    rsp_prod_o   = prod_q;
    rsp_err_o    = err_q;
  end

  // Operand latch, timeout timer, result capture and round-robin history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_id_q <= 1'b1;
      id_q      <= 1'b0;
      opm_q     <= '0;
      opq_q     <= '0;
      prod_q    <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (take) begin
            id_q  <= grant_id;
            opm_q <= grant_id ? req1_m_i : req0_m_i;
            opq_q <= grant_id ? req1_q_i : req0_q_i;
          end
        end
        S_START: timer_q <= '0;
        S_WAIT: begin
          if (done_ok) begin
            prod_q <= mul_prod_i;
            err_q  <= 1'b0;
          end else if (tmo_hit) begin
            prod_q <= '0;
            err_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) last_id_q <= id_q;
        end
        default: ;
      endcase
    end
  end

endmodule
